// File: rtl/branch_control_unit_pkg.sv
// Shared definitions for the branch control unit: opcodes, state encoding and
// the datapath control word.
package branch_control_unit_pkg;

  localparam int unsigned IR_W    = 32;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned COUNT_W = 16;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [STATE_W-1:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic mdr_out;
    logic mar_in;
    logic z_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic inc_pc;
    logic read;
    logic gra;
    logic rout;
    logic cout;
    logic con_in;
    logic add;
  } ctrl_t;

  function automatic logic [OP_W-1:0] opcode_of(input logic [OP_W-1:0] ir_top);
    return ir_top;
  endfunction

  // Every instruction boundary honours a pending Stop request.
  function automatic state_t boundary_next(input logic stop);
    return stop ? ST_HALT : ST_T0;
  endfunction

endpackage

// File: rtl/cu_control_decode.sv
// Moore decode from FSM state to datapath control lines; only PCin in T7
// also looks at the live branch condition.
module cu_control_decode
  import branch_control_unit_pkg::*;
(
  input  state_t state,
  input  logic   branch_met,
  output ctrl_t  ctrl,
  output logic   run
);

  always_comb begin
    ctrl = '0;
    run  = 1'b0;
    case (state)
      ST_T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
        run         = 1'b1;
      end
      ST_T1: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = 1'b1;
        run           = 1'b1;
      end
      ST_T2: begin
        ctrl.read   = 1'b1;
        ctrl.mdr_in = 1'b1;
        run         = 1'b1;
      end
      ST_T3: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        run          = 1'b1;
      end
      ST_T4: begin
        ctrl.gra    = 1'b1;
        ctrl.rout   = 1'b1;
        ctrl.con_in = 1'b1;
        run         = 1'b1;
      end
      ST_T5: begin
        ctrl.pc_out = 1'b1;
        ctrl.y_in   = 1'b1;
        run         = 1'b1;
      end
      ST_T6: begin
        ctrl.cout = 1'b1;
        ctrl.add  = 1'b1;
        ctrl.z_in = 1'b1;
        run       = 1'b1;
      end
      ST_T7: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = branch_met;
        run           = 1'b1;
      end
      default: begin
        ctrl = '0;
        run  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_control_unit.sv
// Fetch/decode/branch sequencer: steps T0..T7, waits on memory in T2,
// counts retired instructions and flags undefined opcodes.
module branch_control_unit
  import branch_control_unit_pkg::*;
(
  input  logic                Clock,
  input  logic                Clear,
  input  logic [IR_W-1:0]     IR,
  input  logic                BranchMet,
  input  logic                Mem_ready,
  input  logic                Stop,
  output logic                PCout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                MARin,
  output logic                Zin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                IncPC,
  output logic                Read,
  output logic                Gra,
  output logic                Rout,
  output logic                Cout,
  output logic                CONIn,
  output logic                ADD,
  output logic                Run,
  output logic                Illegal,
  output logic [COUNT_W-1:0]  Instr_count
);

  state_t          state;
  ctrl_t           ctrl_c;
  logic            run_c;
  logic [OP_W-1:0] opcode;
  logic            unused_ir_bits;

  assign opcode = opcode_of(IR[IR_W-1 -: OP_W]);
  // Operand fields of IR feed the datapath, not this sequencer.
  assign unused_ir_bits = ^IR[IR_W-OP_W-1:0];

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state       <= ST_RST;
      Illegal     <= 1'b0;
      Instr_count <= '0;
    end else begin
      Illegal <= 1'b0;
      case (state)
        ST_RST: state <= boundary_next(Stop);
        ST_T0:  state <= ST_T1;
        ST_T1:  state <= ST_T2;
        ST_T2: begin
          if (Mem_ready) state <= ST_T3;
        end
        ST_T3: begin
          case (opcode)
            OP_BR: state <= ST_T4;
            OP_NOP: begin
              state       <= boundary_next(Stop);
              Instr_count <= Instr_count + COUNT_W'(1);
            end
            OP_HALT: begin
              state       <= ST_HALT;
              Instr_count <= Instr_count + COUNT_W'(1);
            end
            default: begin
              state       <= boundary_next(Stop);
              Illegal     <= 1'b1;
              Instr_count <= Instr_count + COUNT_W'(1);
            end
          endcase
        end
        ST_T4: state <= ST_T5;
        ST_T5: state <= ST_T6;
        ST_T6: state <= ST_T7;
        ST_T7: begin
          state       <= boundary_next(Stop);
          Instr_count <= Instr_count + COUNT_W'(1);
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_RST;
      endcase
    end
  end

  cu_control_decode u_decode (
    .state      (state),
    .branch_met (BranchMet),
    .ctrl       (ctrl_c),
    .run        (run_c)
  );

  assign PCout   = ctrl_c.pc_out;
  assign Zlowout = ctrl_c.zlow_out;
  assign MDRout  = ctrl_c.mdr_out;
  assign MARin   = ctrl_c.mar_in;
  assign Zin     = ctrl_c.z_in;
  assign PCin    = ctrl_c.pc_in;
  assign MDRin   = ctrl_c.mdr_in;
  assign IRin    = ctrl_c.ir_in;
  assign Yin     = ctrl_c.y_in;
  assign IncPC   = ctrl_c.inc_pc;
  assign Read    = ctrl_c.read;
  assign Gra     = ctrl_c.gra;
  assign Rout    = ctrl_c.rout;
  assign Cout    = ctrl_c.cout;
  assign CONIn   = ctrl_c.con_in;
  assign ADD     = ctrl_c.add;
  assign Run     = run_c;

endmodule

// File: tb/tb_branch_control_unit.sv
// Directed bench for branch_control_unit with a step-table reference model
// compared every cycle, plus hand-computed scenario expectations.
module tb_branch_control_unit;

  logic        Clock = 1'b0;
  logic        Clear;
  logic [31:0] IR;
  logic        BranchMet, Mem_ready, Stop;
  logic        PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin;
  logic        Yin, IncPC, Read, Gra, Rout, Cout, CONIn, ADD;
  logic        Run, Illegal;
  logic [15:0] Instr_count;

  localparam logic [31:0] IR_BR   = 32'h91180023;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_BAD  = 32'h00000000;

  branch_control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .BranchMet(BranchMet),
    .Mem_ready(Mem_ready), .Stop(Stop),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin),
    .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .Gra(Gra), .Rout(Rout), .Cout(Cout),
    .CONIn(CONIn), .ADD(ADD), .Run(Run), .Illegal(Illegal),
    .Instr_count(Instr_count)
  );

  always #5 Clock = ~Clock;

  logic [15:0] ctl_act;
  assign ctl_act = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin,
                    Yin, IncPC, Read, Gra, Rout, Cout, CONIn, ADD};

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: step -1 = reset, 0..7 = T0..T7, 8 = halted.
  int          phase   = -1;
  int          m_count = 0;
  bit          m_ill   = 1'b0;
  logic [4:0]  m_op;
  logic [15:0] ctl_tab [8] = '{16'h9840, 16'h4400, 16'h0220, 16'h2100,
                               16'h001A, 16'h8080, 16'h0805, 16'h4000};

  always @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      phase = -1; m_count = 0; m_ill = 1'b0;
    end else begin
      m_ill = 1'b0;
      m_op  = IR[31:27];
      if (phase == -1) phase = Stop ? 8 : 0;
      else if (phase == 2) begin
        if (Mem_ready) phase = 3;
      end else if (phase == 3) begin
        if (m_op == 5'b10010) phase = 4;
        else begin
          m_count = (m_count + 1) % 65536;
          if (m_op == 5'b11011) phase = 8;
          else begin
            m_ill = (m_op != 5'b11010);
            phase = Stop ? 8 : 0;
          end
        end
      end else if (phase == 7) begin
        m_count = (m_count + 1) % 65536;
        phase   = Stop ? 8 : 0;
      end else if (phase < 8) phase = phase + 1;
    end
  end

  function automatic logic [15:0] exp_ctl();
    if (Clear || phase < 0 || phase > 7) return 16'h0000;
    return ctl_tab[phase] | ((phase == 7 && BranchMet) ? 16'h0400 : 16'h0000);
  endfunction

  always @(negedge Clock) begin
    if (chk_en) begin
      check("ctl", 32'(ctl_act), 32'(exp_ctl()));
      check("run", 32'(Run), 32'((!Clear && phase >= 0 && phase <= 7) ? 1 : 0));
      check("illegal", 32'(Illegal), 32'((!Clear && m_ill) ? 1 : 0));
      check("count", 32'(Instr_count), Clear ? 32'd0 : 32'(m_count));
      check("pcout_zlow_excl", 32'(PCout & Zlowout), 32'd0);
      check("read_only_t2", 32'(Read && phase != 2), 32'd0);
    end
  end

  task automatic sample();
    @(negedge Clock); #1;
  endtask

  // Leaves the unit in RST so the next sample() sees T0.
  task automatic do_reset();
    @(posedge Clock); #2;
    Clear = 1'b1; Stop = 1'b0;
    @(posedge Clock); #2;
    Clear = 1'b0;
    @(negedge Clock);
  endtask

  logic pcin_seen [8];
  int   reads, mdrins, irins, t2, quiet;

  initial begin
    Clear = 1'b1; IR = IR_BR; BranchMet = 1'b1; Mem_ready = 1'b1; Stop = 1'b0;
    repeat (2) @(posedge Clock);
    sample();
    check("reset_run", 32'(Run), 32'd0);
    check("reset_ctl", 32'(ctl_act), 32'd0);
    check("reset_count", 32'(Instr_count), 32'd0);
    chk_en = 1'b1;

    // Branch taken
    @(posedge Clock); #2; Clear = 1'b0; @(negedge Clock);
    for (int i = 0; i < 8; i++) begin sample(); pcin_seen[i] = PCin; end
    check("taken_pcin_t0", 32'(pcin_seen[0]), 32'd0);
    check("taken_pcin_t1", 32'(pcin_seen[1]), 32'd1);
    check("taken_pcin_t7", 32'(pcin_seen[7]), 32'd1);
    sample();
    check("taken_next_t0", 32'(MARin), 32'd1);
    check("taken_count", 32'(Instr_count), 32'd1);

    // Branch not taken
    BranchMet = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin sample(); pcin_seen[i] = PCin; end
    check("nt_pcin_t1", 32'(pcin_seen[1]), 32'd1);
    check("nt_pcin_t7", 32'(pcin_seen[7]), 32'd0);
    sample();
    check("nt_next_t0", 32'(MARin), 32'd1);
    check("nt_count", 32'(Instr_count), 32'd1);

    // Memory wait: Mem_ready low for the first three T2 cycles
    BranchMet = 1'b1; Mem_ready = 1'b0;
    do_reset();
    reads = 0; mdrins = 0; irins = 0; t2 = 0;
    for (int i = 0; i < 13; i++) begin
      sample();
      if (Read) begin
        reads++;
        t2++;
        if (t2 == 4) Mem_ready = 1'b1;
      end
      if (MDRin) mdrins++;
      if (IRin) irins++;
    end
    check("wait_read_cycles", 32'(reads), 32'd4);
    check("wait_mdrin_cycles", 32'(mdrins), 32'd4);
    check("wait_irin_cycles", 32'(irins), 32'd1);

    // Halt opcode
    IR = IR_HALT;
    do_reset();
    repeat (4) sample();
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (!Run && ctl_act == 16'h0000) quiet++;
    end
    check("halt_quiet_cycles", 32'(quiet), 32'd20);
    check("halt_count", 32'(Instr_count), 32'd1);

    // Stop raised during a branch
    IR = IR_BR;
    do_reset();
    repeat (3) sample();
    Stop = 1'b1;
    repeat (5) sample();
    check("stop_t7_ctl", 32'(ctl_act), 32'h4400);
    sample();
    check("stop_halt_run", 32'(Run), 32'd0);
    check("stop_halt_ctl", 32'(ctl_act), 32'd0);
    check("stop_count", 32'(Instr_count), 32'd1);
    Stop = 1'b0;

    // Undefined opcode
    IR = IR_BAD;
    do_reset();
    repeat (4) sample();
    sample();
    check("illegal_pulse", 32'(Illegal), 32'd1);
    check("illegal_back_t0", 32'(MARin), 32'd1);
    sample();
    check("illegal_one_cycle", 32'(Illegal), 32'd0);
    check("illegal_count", 32'(Instr_count), 32'd1);

    // Clear asserted in T5
    IR = IR_BR;
    do_reset();
    repeat (6) sample();
    check("t5_ctl", 32'(ctl_act), 32'h8080);
    Clear = 1'b1;
    #1;
    check("clear_async_ctl", 32'(ctl_act), 32'd0);
    check("clear_async_run", 32'(Run), 32'd0);
    check("clear_async_count", 32'(Instr_count), 32'd0);
    @(posedge Clock); #2; Clear = 1'b0; @(negedge Clock);
    sample();
    check("clear_then_t0", 32'(ctl_act), 32'h9840);
    check("clear_then_run", 32'(Run), 32'd1);

    repeat (2) sample();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
